i2c_reg_responder: RTL and testbench



---
 rtl/i2c_reg_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_reg_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_responder.sv
// I2C target mapping a 7-bit device address onto an 8-bit register port:
// sub-address writes, sequential reads, auto-incrementing register pointer.
module i2c_reg_responder #(
    parameter logic [6:0]  DEV_ADDR = 7'h39,
    parameter int unsigned FILTER   = 3
) (
    input  logic       clk_sys,
    input  logic       res_n,
    input  logic       I2C_SCL,
    input  logic       I2C_SDA_I,
    output logic       I2C_SDA_OE,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    logic [1:0]    scl_sync_q, sda_sync_q;
    logic [CW-1:0] scl_cnt_q, sda_cnt_q;
    logic          scl_f_q, sda_f_q, scl_fp_q, sda_fp_q;
    logic          scl_rise, scl_fall, start_det, stop_det;

    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          rw_q, rw_d;
    logic          sda_oe_q, sda_oe_d;
    logic          we_q, we_d;
    logic          re_q, re_d;
    logic          busy_q, busy_d;
    logic          re_dly_q;

    // Sync flops and filters reset to 1 (idle bus) so release never fakes an edge.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_fp_q   <= 1'b1;
            sda_fp_q   <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], I2C_SCL};
            sda_sync_q <= {sda_sync_q[0], I2C_SDA_I};
            scl_fp_q   <= scl_f_q;
            sda_fp_q   <= sda_f_q;
            if (scl_sync_q[1] == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == CW'(FILTER - 1)) begin
                scl_f_q   <= scl_sync_q[1];
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + CW'(1);
            end
            if (sda_sync_q[1] == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == CW'(FILTER - 1)) begin
                sda_f_q   <= sda_sync_q[1];
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + CW'(1);
            end
        end
    end

    assign scl_rise  = scl_f_q & ~scl_fp_q;
    assign scl_fall  = ~scl_f_q & scl_fp_q;
    assign start_det = scl_f_q & scl_fp_q & sda_fp_q & ~sda_f_q;
    assign stop_det  = scl_f_q & scl_fp_q & ~sda_fp_q & sda_f_q;

    // Register port: reg_we/reg_re are single-cycle strobes, never together;
    // reg_rdata is captured into the shift register one clock after reg_re.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        busy_d    = busy_q;
        if (re_dly_q) shift_d = reg_rdata;
        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, SUB, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_f_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (state_q == WDATA && bit_cnt_q == 4'd7) begin
                            wdata_d = {shift_q[6:0], sda_f_q};
                            we_d    = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                state_d  = ADDR_ACK;
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                                rw_d     = shift_q[0];
                            end else begin
                                state_d = IGNORE;
                            end
                        end else begin
                            if (state_q == SUB) addr_d = shift_q;
                            state_d  = (state_q == SUB) ? SUB_ACK : WDATA_ACK;
                            sda_oe_d = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_rise) begin
                        re_d = rw_q;
                    end else if (scl_fall) begin
                        if (rw_q) begin
                            state_d  = RDATA;
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                        end else begin
                            state_d  = SUB;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                SUB_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d  = WDATA;
                        sda_oe_d = 1'b0;
                        if (state_q == WDATA_ACK) addr_d = addr_q + 8'd1;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                            state_d   = RDATA_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                RDATA_ACK: begin
                    // Pointer advances past every byte sent, so it names the next unread register.
                    if (scl_rise) begin
                        addr_d = addr_q + 8'd1;
                        if (!sda_f_q) re_d = 1'b1;
                        else state_d = IGNORE;
                    end else if (scl_fall) begin
                        state_d  = RDATA;
                        sda_oe_d = ~shift_q[7];
                        shift_d  = {shift_q[6:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            busy_q    <= 1'b0;
            re_dly_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            sda_oe_q  <= sda_oe_d;
            we_q      <= we_d;
            re_q      <= re_d;
            busy_q    <= busy_d;
            re_dly_q  <= re_q;
        end
    end

    assign I2C_SDA_OE = sda_oe_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = wdata_q;
    assign reg_we     = we_q;
    assign reg_re     = re_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_reg_responder.sv
// Directed bench for i2c_reg_responder: bit-banged I2C master, register model
// returning addr ^ 0x5A, and a write scoreboard.
module tb_i2c_reg_responder;

    logic       clk_sys = 1'b0;
    logic       res_n   = 1'b0;
    logic       scl     = 1'b1;
    logic       sda_m   = 1'b1;
    logic       sda_bus;
    logic       oe;
    logic [7:0] reg_addr, reg_wdata, rdata_m;
    logic       reg_we, reg_re, busy;

    assign sda_bus = sda_m & ~oe;

    always #5 clk_sys = ~clk_sys;

    i2c_reg_responder #(.DEV_ADDR(7'h39), .FILTER(3)) dut (
        .clk_sys    (clk_sys),
        .res_n      (res_n),
        .I2C_SCL    (scl),
        .I2C_SDA_I  (sda_bus),
        .I2C_SDA_OE (oe),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (rdata_m),
        .busy       (busy)
    );

    initial rdata_m = 8'h00;
    always @(posedge clk_sys) if (reg_re) rdata_m <= reg_addr ^ 8'h5A;

    int          we_cnt = 0, re_cnt = 0, oe_cnt = 0, busy_cnt = 0, strobe_err = 0;
    logic [15:0] act_log [0:63];
    logic        prev_we = 1'b0, prev_re = 1'b0;

    always @(negedge clk_sys) begin
        if (reg_we) begin
            if (we_cnt < 64) act_log[we_cnt] = {reg_addr, reg_wdata};
            we_cnt++;
        end
        if ((reg_we && reg_re) || (reg_we && prev_we) || (reg_re && prev_re)) strobe_err++;
        prev_we = reg_we;
        prev_re = reg_re;
        if (reg_re) re_cnt++;
        if (oe)     oe_cnt++;
        if (busy)   busy_cnt++;
    end

    int          checks = 0, errors = 0, rd_idx = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [7:0] dev, sub, d0, d1;
        logic       ack;
        logic [7:0] addr;
    } wr_vec_t;
    wr_vec_t tbl [4];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; tick(10); scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        tick(5); sda_m = 1'b1; tick(5); scl = 1'b1; tick(10);
        i2c_start();
    endtask

    task automatic i2c_stop();
        tick(5); sda_m = 1'b0; tick(5); scl = 1'b1; tick(10); sda_m = 1'b1; tick(10);
    endtask

    task automatic send_bit(input logic b);
        tick(5); sda_m = b; tick(5); scl = 1'b1; tick(10); scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        tick(5); sda_m = 1'b1; tick(5); scl = 1'b1; tick(5); b = sda_bus; tick(5); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(mack ? 1'b0 : 1'b1);
    endtask

    task automatic check_writes(input string tag);
        logic [15:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < we_cnt) begin
                check({tag, "_we"}, act_log[rd_idx], e);
            end else begin
                checks++;
                errors++;
                $display("FAIL %s_we_missing: got none expected 0x%0h", tag, e);
            end
            rd_idx++;
        end
        check({tag, "_we_count"}, 16'(we_cnt), 16'(rd_idx));
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        int         oe0, busy0, re0;
        string      tag;

        tbl[0] = '{8'h72, 8'h10, 8'hAB, 8'hCD, 1'b1, 8'h12};
        tbl[1] = '{8'h70, 8'h10, 8'h55, 8'h66, 1'b0, 8'h12};
        tbl[2] = '{8'h72, 8'hFF, 8'h01, 8'h02, 1'b1, 8'h01};
        tbl[3] = '{8'h7E, 8'h33, 8'h44, 8'h55, 1'b0, 8'h01};

        tick(5);
        check("rst_oe", 16'(oe), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        res_n = 1'b1;
        tick(10);
        check("rst_addr", 16'(reg_addr), 16'h0);
        check("rst_wdata", 16'(reg_wdata), 16'h0);
        check("rst_we", 16'(reg_we), 16'h0);
        check("rst_re", 16'(reg_re), 16'h0);

        for (int v = 0; v < 4; v++) begin
            tag   = $sformatf("wr%0d", v);
            oe0   = oe_cnt;
            busy0 = busy_cnt;
            if (tbl[v].ack) begin
                d = tbl[v].sub + 8'd1;
                exp_q.push_back({tbl[v].sub, tbl[v].d0});
                exp_q.push_back({d, tbl[v].d1});
            end
            i2c_start();
            write_byte(tbl[v].dev, a); check({tag, "_ack_dev"}, 16'(a), 16'(tbl[v].ack));
            write_byte(tbl[v].sub, a); check({tag, "_ack_sub"}, 16'(a), 16'(tbl[v].ack));
            write_byte(tbl[v].d0, a);  check({tag, "_ack_d0"}, 16'(a), 16'(tbl[v].ack));
            write_byte(tbl[v].d1, a);  check({tag, "_ack_d1"}, 16'(a), 16'(tbl[v].ack));
            i2c_stop();
            tick(10);
            check({tag, "_busy_after_p"}, 16'(busy), 16'h0);
            check({tag, "_reg_addr"}, 16'(reg_addr), 16'(tbl[v].addr));
            check({tag, "_oe_active"}, 16'(oe_cnt != oe0), 16'(tbl[v].ack));
            check({tag, "_busy_active"}, 16'(busy_cnt != busy0), 16'(tbl[v].ack));
            check_writes(tag);
        end

        // Combined read with repeated start across the 0xFF boundary.
        re0 = re_cnt;
        i2c_start();
        write_byte(8'h72, a); check("rd_ack_dev", 16'(a), 16'h1);
        write_byte(8'hFE, a); check("rd_ack_sub", 16'(a), 16'h1);
        i2c_rstart();
        write_byte(8'h73, a); check("rd_ack_devr", 16'(a), 16'h1);
        read_byte(1'b1, d);   check("rd_byte0", 16'(d), 16'hA4);
        read_byte(1'b0, d);   check("rd_byte1", 16'(d), 16'hA5);
        tick(10);
        check("rd_addr_wrap", 16'(reg_addr), 16'h00);
        check("rd_oe_released", 16'(oe), 16'h0);
        i2c_stop();
        tick(10);
        check("rd_busy_after_p", 16'(busy), 16'h0);
        check("rd_re_count", 16'(re_cnt - re0), 16'd2);
        check_writes("rd");

        // SDA glitch in IDLE must not start a transfer; an unframed 0x72 then gets no ACK.
        oe0 = oe_cnt;
        sda_m = 1'b0; tick(1); sda_m = 1'b1; tick(20);
        scl = 1'b0; tick(10);
        write_byte(8'h72, a);
        check("glitch_no_ack", 16'(a), 16'h0);
        check("glitch_busy", 16'(busy), 16'h0);
        check("glitch_oe_idle", 16'(oe_cnt - oe0), 16'h0);
        tick(5); scl = 1'b1; tick(20);

        // Short SCL pulse inside a WDATA byte must not shift a bit.
        exp_q.push_back({8'h30, 8'h5C});
        i2c_start();
        write_byte(8'h72, a); check("gl_ack_dev", 16'(a), 16'h1);
        write_byte(8'h30, a); check("gl_ack_sub", 16'(a), 16'h1);
        d = 8'h5C;
        for (int i = 7; i >= 0; i--) begin
            if (i == 3) begin
                tick(10); scl = 1'b1; tick(2); scl = 1'b0; tick(10);
            end
            send_bit(d[i]);
        end
        recv_bit(a);
        check("gl_ack_data", 16'(a), 16'h0);
        i2c_stop();
        tick(10);
        check("gl_reg_addr", 16'(reg_addr), 16'h31);
        check_writes("gl");

        // STOP after half a data byte: pointer kept, no write strobe.
        i2c_start();
        write_byte(8'h72, a); check("part_ack_dev", 16'(a), 16'h1);
        write_byte(8'h20, a); check("part_ack_sub", 16'(a), 16'h1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        tick(10);
        check("part_reg_addr", 16'(reg_addr), 16'h20);
        check("part_busy", 16'(busy), 16'h0);
        check_writes("part");

        // Reset while the responder drives a 0 data bit (0x40 ^ 0x5A = 0x1A, MSB 0).
        i2c_start();
        write_byte(8'h72, a);
        write_byte(8'h40, a);
        i2c_rstart();
        write_byte(8'h73, a); check("rr_ack_devr", 16'(a), 16'h1);
        tick(5); sda_m = 1'b1; tick(5); scl = 1'b1; tick(5);
        check("rr_oe_driving", 16'(oe), 16'h1);
        res_n = 1'b0;
        #1;
        check("rr_oe_async", 16'(oe), 16'h0);
        tick(2);
        check("rr_addr", 16'(reg_addr), 16'h0);
        check("rr_wdata", 16'(reg_wdata), 16'h0);
        check("rr_we", 16'(reg_we), 16'h0);
        check("rr_re", 16'(reg_re), 16'h0);
        check("rr_busy", 16'(busy), 16'h0);
        sda_m = 1'b1; scl = 1'b1; tick(5);
        res_n = 1'b1;
        tick(20);
        exp_q.push_back({8'h50, 8'h11});
        exp_q.push_back({8'h51, 8'h22});
        i2c_start();
        write_byte(8'h72, a); check("post_ack_dev", 16'(a), 16'h1);
        write_byte(8'h50, a); check("post_ack_sub", 16'(a), 16'h1);
        write_byte(8'h11, a); check("post_ack_d0", 16'(a), 16'h1);
        write_byte(8'h22, a); check("post_ack_d1", 16'(a), 16'h1);
        i2c_stop();
        tick(10);
        check("post_reg_addr", 16'(reg_addr), 16'h52);
        check("post_busy", 16'(busy), 16'h0);
        check_writes("post");

        check("strobe_shape", 16'(strobe_err), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
